seg_scan_driver: RTL
====================

# seg_scan_driver

Time-multiplexed driver for a multi-digit common-anode seven-segment display. Sits directly downstream of the digit counters: accepts one 4-bit hex code per digit and scans them onto a single shared segment bus with one-hot digit enables. Inserts a blanking gap between digits to suppress ghosting, optionally suppresses leading zeros, and latches new values only at frame boundaries so a digit never tears mid-scan.

## Interface
- `DIGITS`, 4: number of digits scanned, 2..8.
- `DWELL`, 50000: clock cycles each digit is lit, ≥1.
- `BLANK`, 16: clock cycles with all digits off between digits, ≥1.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous assert, active-low; synchronous deassert is handled upstream.
- `value` in 4*DIGITS: hex code per digit; digit i = `value[4i+3:4i]`; digit 0 is rightmost (LSD).
- `dp_en` in DIGITS: decimal-point request per digit.
- `load` in 1: capture `value`/`dp_en` into the pending buffer this cycle.
- `lz_en` in 1: leading-zero suppression enable; sampled at each frame commit.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-high.
- `dp` out 1: decimal point, active-high.
- `an` out DIGITS: one-hot digit enable, active-high; all-zero while blanking.
- `frame` out 1: one-cycle pulse on the frame commit cycle.

## Operation
- FSM states: `BLANK`, `SHOW`. Reset state `BLANK`, digit index 0, cycle counter 0.
- `BLANK`: counter runs 0..BLANK-1, then → `SHOW`, counter cleared. `SHOW`: counter runs 0..DWELL-1, then → `BLANK`, counter cleared, index advances; DIGITS-1 wraps to 0.
- The `SHOW`→`BLANK` transition out of digit DIGITS-1 is the frame commit: `frame`=1 for the first cycle of that `BLANK`.
- Buffering: `load`=1 writes pending buffer and sets `pend`. On commit, if `pend`, pending → shadow and `pend` clears. `load` in the commit cycle itself writes both pending and shadow directly, leaving `pend` clear. `load` mid-frame never changes displayed digits before the next commit.
- Display path uses shadow registers only. Reset: shadow, pending, `pend`, latched `lz_en` all 0.
- Hex decode (per digit): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Leading-zero suppression (when latched `lz_en`=1): digit i is blanked (`seg`=0) iff shadow codes of digits DIGITS-1..i are all 0 and i>0. Digit 0 always shows. `dp` for a suppressed digit still follows `dp_en`.
- Outputs during `BLANK`: `an`, `seg`, `dp` all 0.

## Timing
- Reset values: `seg`=0, `dp`=0, `an`=0, `frame`=0.
- All outputs registered; no combinational input→output path.
- After `rst` deasserts, first `BLANK` lasts BLANK cycles; `an[0]` rises on the edge ending it.
- Each digit: `an` high exactly DWELL cycles, then exactly BLANK cycles all-off. Frame period = DIGITS*(DWELL+BLANK) cycles; `frame` pulses once per period.
- `seg`/`dp`/`an` change on the same edge; never a cycle with `an`≠0 and stale `seg`.
- Load-to-display latency: first `SHOW` after the next commit (worst case one frame period + BLANK).
- `rst` asserted mid-operation: outputs to reset values immediately (asynchronous); buffered values discarded.

## Structure
- Package `seg_scan_pkg`: FSM state enum (`BLANK`, `SHOW`), 16-entry hex-to-segment constant table, segment bit-order constants.
- One sub-module `hex_seg7`: combinational 4-bit code → 7-bit segment pattern from the package table; instantiated once on the muxed digit code.
- Counter width = $clog2(max(DWELL,BLANK)); index width = $clog2(DIGITS).

## Test plan
All with DIGITS=4, DWELL=4, BLANK=2.
- Reset release, `value`=0 → `an` pattern 0 for 2 cycles, then 0001 for 4, 0 for 2, 0010 for 4, ...; `frame` every 24 cycles; `seg`=3F while lit.
- `load` with `value`=16'h1A2F, `dp_en`=4'b0100 mid-frame → unchanged until commit; next frame shows digit0 `seg`=71, digit1 5B, digit2 77 with `dp`=1, digit3 06.
- `lz_en`=1, `value`=16'h0070 → digits 3 and 2 `seg`=0 (`an` still scans), digit1 07, digit0 3F; `value`=0 → only digit 0 shows 3F.
- `load` asserted exactly on the `frame` cycle with 16'h8888 → that frame's digits all `seg`=7F; a second `load` 3 cycles later with 16'h0000 appears only the frame after.
- `rst` pulled low while `an`=0100 → `an`,`seg`,`dp`,`frame` go 0 without a clock edge; after release, scan restarts at digit 0 with shadow 0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver:
// scan state encoding, segment bit positions and the hex glyph table.
package seg_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = 7;

  // Glyphs as {g,f,e,d,c,b,a}; the first element is code F, the last is code 0.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_seg7.sv
// Combinational hex code to seven-segment glyph lookup, active-high segments.
module hex_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0]       code,
  output logic [SEG_W-1:0] seg
);

  logic [SEG_W-1:0] pattern;

  // Output is assembled by named segment so the bus order stays explicit.
  always_comb begin
    pattern = HEX_SEG[code];
    seg     = {pattern[SEG_G], pattern[SEG_F], pattern[SEG_E], pattern[SEG_D],
               pattern[SEG_C], pattern[SEG_B], pattern[SEG_A]};
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode display driver: blank gap between digits,
// frame-boundary double buffering and optional leading-zero suppression.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_en,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(DIGITS);

  localparam logic [CW-1:0] DWELL_END  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK - 1);
  localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);

  scan_state_t             state, nstate;
  logic [CW-1:0]           cnt, ncnt;
  logic [IW-1:0]           idx, nidx;
  logic                    frameNext;

  logic [4*DIGITS-1:0]     pendVal, shadowVal, nshVal;
  logic [DIGITS-1:0]       pendDp, shadowDp, nshDp;
  logic                    pend, lzq, nlz;

  logic [3:0]              curCode;
  logic [SEG_W-1:0]        decSeg;
  logic                    curDp, suppress, allZero;

  always_comb begin
    nstate    = state;
    ncnt      = cnt + CW'(1);
    nidx      = idx;
    frameNext = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_END) begin
          nstate = ST_SHOW;
          ncnt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == DWELL_END) begin
          nstate    = ST_BLANK;
          ncnt      = '0;
          nidx      = (idx == LAST_DIGIT) ? '0 : idx + IW'(1);
          frameNext = (idx == LAST_DIGIT);
        end
      end
      default: begin
        nstate = ST_BLANK;
        ncnt   = '0;
      end
    endcase
  end

  // The frame cycle is the commit point; a load in that same cycle wins over
  // the pending buffer and goes straight to the shadow copy.
  always_comb begin
    nshVal = shadowVal;
    nshDp  = shadowDp;
    nlz    = lzq;
    if (frame) begin
      nlz = lz_en;
      if (load) begin
        nshVal = value;
        nshDp  = dp_en;
      end else if (pend) begin
        nshVal = pendVal;
        nshDp  = pendDp;
      end
    end
  end

  // Look ahead at the digit about to be lit so segments land with its anode.
  always_comb begin
    curCode  = nshVal[nidx*4 +: 4];
    curDp    = nshDp[nidx];
    suppress = 1'b0;
    allZero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allZero = allZero && (nshVal[4*i +: 4] == 4'd0);
      if (i == int'(nidx)) begin
        suppress = nlz && allZero && (i > 0);
      end
    end
  end

  hex_seg7 u_hex_seg7 (
    .code (curCode),
    .seg  (decSeg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_BLANK;
      cnt       <= '0;
      idx       <= '0;
      frame     <= 1'b0;
      pendVal   <= '0;
      pendDp    <= '0;
      pend      <= 1'b0;
      shadowVal <= '0;
      shadowDp  <= '0;
      lzq       <= 1'b0;
      seg       <= '0;
      dp        <= 1'b0;
      an        <= '0;
    end else begin
      state     <= nstate;
      cnt       <= ncnt;
      idx       <= nidx;
      frame     <= frameNext;
      shadowVal <= nshVal;
      shadowDp  <= nshDp;
      lzq       <= nlz;
      if (load) begin
        pendVal <= value;
        pendDp  <= dp_en;
        pend    <= !frame;
      end else if (frame) begin
        pend <= 1'b0;
      end
      if (nstate == ST_SHOW) begin
        an  <= {{(DIGITS-1){1'b0}}, 1'b1} << nidx;
        seg <= suppress ? '0 : decSeg;
        dp  <= curDp;
      end else begin
        an  <= '0;
        seg <= '0;
        dp  <= 1'b0;
      end
    end
  end

endmodule
